// File: rtl/vrf_bank_read_responder.sv
// vrf_bank_read_responder
// One VRF bank with one read port and one write port. The bank answers
// read-request handshakes with the addressed word exactly two cycles later.
// After reset it zeroes every entry, and it accepts no traffic until that
// clearing pass is finished.
// Ports:
//   clock, reset                  - clock and synchronous active-high reset
//   vrfReadRequest_*              - read request handshake (vs, offset, tags)
//   vrfReadResult*                - read data, valid pulse and echoed tags
//   vrfWriteRequest_*             - write request handshake (vs, offset, data, byte mask)
module vrf_bank_read_responder #(
  parameter int unsigned regNumBits = 5,
  parameter int unsigned offsetBits = 2,
  parameter int unsigned dataWidth  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      vrfReadRequest_ready,
  input  logic                      vrfReadRequest_valid,
  input  logic [regNumBits-1:0]     vrfReadRequest_bits_vs,
  input  logic [offsetBits-1:0]     vrfReadRequest_bits_offset,
  input  logic [1:0]                vrfReadRequest_bits_readSource,
  input  logic [2:0]                vrfReadRequest_bits_instructionIndex,
  output logic [dataWidth-1:0]      vrfReadResult,
  output logic                      vrfReadResultValid,
  output logic [1:0]                vrfReadResultSource,
  output logic [2:0]                vrfReadResultInstructionIndex,
  output logic                      vrfWriteRequest_ready,
  input  logic                      vrfWriteRequest_valid,
  input  logic [regNumBits-1:0]     vrfWriteRequest_bits_vs,
  input  logic [offsetBits-1:0]     vrfWriteRequest_bits_offset,
  input  logic [dataWidth-1:0]      vrfWriteRequest_bits_data,
  input  logic [dataWidth/8-1:0]    vrfWriteRequest_bits_mask
);

  localparam int unsigned AddrW   = regNumBits + offsetBits;
  localparam int unsigned Depth   = 1 << AddrW;
  localparam int unsigned ByteNum = dataWidth / 8;

  typedef enum logic {
    sInit = 1'b0,
    sRun  = 1'b1
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [AddrW-1:0]   initPtr;
  logic [AddrW-1:0]   initPtrNext;

  logic [dataWidth-1:0] mem [Depth];

  logic               readFire;
  logic               wrFire;
  logic [AddrW-1:0]   rdAddr;
  logic [AddrW-1:0]   wrAddr;

  logic               s1V;
  logic [AddrW-1:0]   s1Addr;
  logic [1:0]         s1Src;
  logic [2:0]         s1Idx;
  logic [dataWidth-1:0] s2Data;

  // The ready outputs are a decode of the state flop only, never of any valid input.
  assign vrfReadRequest_ready  = (state == sRun);
  assign vrfWriteRequest_ready = (state == sRun);

  assign readFire = vrfReadRequest_ready & vrfReadRequest_valid;
  assign wrFire   = vrfWriteRequest_ready & vrfWriteRequest_valid;
  assign rdAddr   = {vrfReadRequest_bits_vs, vrfReadRequest_bits_offset};
  assign wrAddr   = {vrfWriteRequest_bits_vs, vrfWriteRequest_bits_offset};

  // State register and clearing pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= sInit;
      initPtr <= '0;
    end else begin
      state   <= stateNext;
      initPtr <= initPtrNext;
    end
  end

  // Next-state logic: run through every entry once, then go to RUN.
  always_comb begin
    stateNext   = state;
    initPtrNext = initPtr;
    case (state)
      sInit: begin
        initPtrNext = initPtr + AddrW'(1);
        if (initPtr == AddrW'(Depth - 1)) begin
          stateNext = sRun;
        end
      end
      sRun: begin
        stateNext = sRun;
      end
      default: begin
        stateNext = sInit;
      end
    endcase
  end

  // Storage: zero fill while in INIT, byte-masked writes while in RUN.
  always_ff @(posedge clock) begin
    if (state == sInit) begin
      mem[initPtr] <= '0;
    end else if (wrFire) begin
      for (int i = 0; i < int'(ByteNum); i++) begin
        if (vrfWriteRequest_bits_mask[i]) begin
          mem[wrAddr][i*8 +: 8] <= vrfWriteRequest_bits_data[i*8 +: 8];
        end
      end
    end
  end

  // A write firing in the S1 cycle is merged into the data the S2 stage
  // captures, so the read sees every write up to and including that cycle.
  always_comb begin
    s2Data = mem[s1Addr];
    for (int i = 0; i < int'(ByteNum); i++) begin
      if (wrFire && (wrAddr == s1Addr) && vrfWriteRequest_bits_mask[i]) begin
        s2Data[i*8 +: 8] = vrfWriteRequest_bits_data[i*8 +: 8];
      end
    end
  end

  // Two-stage read pipeline. The S2 registers hold their value between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1V                           <= 1'b0;
      s1Addr                        <= '0;
      s1Src                         <= '0;
      s1Idx                         <= '0;
      vrfReadResultValid            <= 1'b0;
      vrfReadResult                 <= '0;
      vrfReadResultSource           <= '0;
      vrfReadResultInstructionIndex <= '0;
    end else begin
      s1V <= readFire;
      if (readFire) begin
        s1Addr <= rdAddr;
        s1Src  <= vrfReadRequest_bits_readSource;
        s1Idx  <= vrfReadRequest_bits_instructionIndex;
      end
      vrfReadResultValid <= s1V;
      if (s1V) begin
        vrfReadResult                 <= s2Data;
        vrfReadResultSource           <= s1Src;
        vrfReadResultInstructionIndex <= s1Idx;
      end
    end
  end

endmodule

// File: tb/tb_vrf_bank_read_responder.sv
// Directed bench for vrf_bank_read_responder. The bench drives inputs on the
// falling edge and samples outputs on the falling edge.
module tb_vrf_bank_read_responder;

  logic        clock;
  logic        reset;
  logic        rdReady;
  logic        rdValid;
  logic [4:0]  rdVs;
  logic [1:0]  rdOffset;
  logic [1:0]  rdSource;
  logic [2:0]  rdIdx;
  logic [31:0] resData;
  logic        resValid;
  logic [1:0]  resSource;
  logic [2:0]  resIdx;
  logic        wrReady;
  logic        wrValid;
  logic [4:0]  wrVs;
  logic [1:0]  wrOffset;
  logic [31:0] wrData;
  logic [3:0]  wrMask;

  int checks   = 0;
  int failures = 0;

  vrf_bank_read_responder dut (
    .clock                                (clock),
    .reset                                (reset),
    .vrfReadRequest_ready                 (rdReady),
    .vrfReadRequest_valid                 (rdValid),
    .vrfReadRequest_bits_vs               (rdVs),
    .vrfReadRequest_bits_offset           (rdOffset),
    .vrfReadRequest_bits_readSource       (rdSource),
    .vrfReadRequest_bits_instructionIndex (rdIdx),
    .vrfReadResult                        (resData),
    .vrfReadResultValid                   (resValid),
    .vrfReadResultSource                  (resSource),
    .vrfReadResultInstructionIndex        (resIdx),
    .vrfWriteRequest_ready                (wrReady),
    .vrfWriteRequest_valid                (wrValid),
    .vrfWriteRequest_bits_vs              (wrVs),
    .vrfWriteRequest_bits_offset          (wrOffset),
    .vrfWriteRequest_bits_data            (wrData),
    .vrfWriteRequest_bits_mask            (wrMask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on the falling edge right after reset deasserts.
  task automatic waitInit(input string tag);
    for (int k = 0; k < 128; k++) begin
      chk({tag, "_rd_ready_low"}, 32'(rdReady), 32'h0);
      chk({tag, "_wr_ready_low"}, 32'(wrReady), 32'h0);
      @(negedge clock);
    end
    chk({tag, "_rd_ready_high"}, 32'(rdReady), 32'h1);
    chk({tag, "_wr_ready_high"}, 32'(wrReady), 32'h1);
    chk({tag, "_no_result_pulse"}, 32'(resValid), 32'h0);
  endtask

  task automatic doWrite(input logic [4:0] vs, input logic [1:0] off,
                         input logic [31:0] data, input logic [3:0] mask);
    wrValid  = 1'b1;
    wrVs     = vs;
    wrOffset = off;
    wrData   = data;
    wrMask   = mask;
    @(negedge clock);
    wrValid  = 1'b0;
  endtask

  task automatic doRead(input string tag, input logic [4:0] vs, input logic [1:0] off,
                        input logic [1:0] src, input logic [2:0] idx,
                        input logic [31:0] expData);
    rdValid  = 1'b1;
    rdVs     = vs;
    rdOffset = off;
    rdSource = src;
    rdIdx    = idx;
    @(negedge clock);
    rdValid  = 1'b0;
    chk({tag, "_valid_t1"}, 32'(resValid), 32'h0);
    @(negedge clock);
    chk({tag, "_valid_t2"}, 32'(resValid), 32'h1);
    chk({tag, "_data"}, resData, expData);
    chk({tag, "_source"}, 32'(resSource), 32'(src));
    chk({tag, "_index"}, 32'(resIdx), 32'(idx));
    @(negedge clock);
    chk({tag, "_valid_t3"}, 32'(resValid), 32'h0);
    chk({tag, "_data_held"}, resData, expData);
  endtask

  initial begin
    reset    = 1'b1;
    rdValid  = 1'b0;
    rdVs     = '0;
    rdOffset = '0;
    rdSource = '0;
    rdIdx    = '0;
    wrValid  = 1'b0;
    wrVs     = '0;
    wrOffset = '0;
    wrData   = '0;
    wrMask   = '0;

    // Reset values.
    repeat (3) @(negedge clock);
    chk("rst_rd_ready", 32'(rdReady), 32'h0);
    chk("rst_wr_ready", 32'(wrReady), 32'h0);
    chk("rst_res_valid", 32'(resValid), 32'h0);
    chk("rst_res_data", resData, 32'h0);
    chk("rst_res_source", 32'(resSource), 32'h0);
    chk("rst_res_index", 32'(resIdx), 32'h0);

    // INIT lasts exactly 128 cycles.
    reset = 1'b0;
    waitInit("init");

    // The top entry was cleared.
    doRead("rd_7f", 5'd31, 2'd3, 2'd1, 3'd2, 32'h0000_0000);

    // Full write and readback with the tags echoed.
    doWrite(5'd3, 2'd1, 32'hDEAD_BEEF, 4'hF);
    doRead("rd_full", 5'd3, 2'd1, 2'd2, 3'd5, 32'hDEAD_BEEF);

    // A partial write replaces only bytes 0 and 2.
    doWrite(5'd3, 2'd1, 32'h1122_3344, 4'b0101);
    doRead("rd_partial", 5'd3, 2'd1, 2'd3, 3'd7, 32'hDE22_BE44);

    // Forwarding: the read of addr 5 fires in T, the write in T+1.
    rdValid = 1'b1; rdVs = 5'd1; rdOffset = 2'd1; rdSource = 2'd0; rdIdx = 3'd1;
    @(negedge clock);
    rdValid = 1'b0;
    wrValid = 1'b1; wrVs = 5'd1; wrOffset = 2'd1; wrData = 32'hCAFE_F00D; wrMask = 4'hF;
    @(negedge clock);
    wrValid = 1'b0;
    chk("fwd_t1_valid", 32'(resValid), 32'h1);
    chk("fwd_t1_data", resData, 32'hCAFE_F00D);
    @(negedge clock);

    // A write in T+2 is too late, so the read returns the old value.
    rdValid = 1'b1; rdVs = 5'd1; rdOffset = 2'd1; rdSource = 2'd1; rdIdx = 3'd3;
    @(negedge clock);
    rdValid = 1'b0;
    @(negedge clock);
    wrValid = 1'b1; wrVs = 5'd1; wrOffset = 2'd1; wrData = 32'h1234_5678; wrMask = 4'hF;
    chk("fwd_t2_valid", 32'(resValid), 32'h1);
    chk("fwd_t2_data", resData, 32'hCAFE_F00D);
    @(negedge clock);
    wrValid = 1'b0;
    doRead("rd_after_late", 5'd1, 2'd1, 2'd0, 3'd0, 32'h1234_5678);

    // A write in the same cycle as the read fire is visible to that read.
    rdValid = 1'b1; rdVs = 5'd1; rdOffset = 2'd2; rdSource = 2'd2; rdIdx = 3'd4;
    wrValid = 1'b1; wrVs = 5'd1; wrOffset = 2'd2; wrData = 32'h0BAD_CAFE; wrMask = 4'b1100;
    @(negedge clock);
    rdValid = 1'b0;
    wrValid = 1'b0;
    @(negedge clock);
    chk("same_cyc_valid", 32'(resValid), 32'h1);
    chk("same_cyc_data", resData, 32'h0BAD_0000);
    @(negedge clock);

    // Back-to-back reads of addrs 0..3.
    for (int a = 0; a < 4; a++) begin
      doWrite(5'd0, 2'(a), 32'(a) * 32'h0101_0101, 4'hF);
    end
    for (int k = 0; k < 7; k++) begin
      if (k >= 2 && k < 6) begin
        chk("b2b_valid", 32'(resValid), 32'h1);
        chk("b2b_data", resData, 32'(k - 2) * 32'h0101_0101);
      end else begin
        chk("b2b_idle", 32'(resValid), 32'h0);
      end
      rdValid  = (k < 4);
      rdVs     = 5'd0;
      rdOffset = 2'(k);
      @(negedge clock);
    end
    rdValid = 1'b0;

    // Reset in the cycle after a read fires drops that read.
    rdValid = 1'b1; rdVs = 5'd3; rdOffset = 2'd1; rdSource = 2'd3; rdIdx = 3'd6;
    @(negedge clock);
    rdValid = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    chk("rst_mid_valid", 32'(resValid), 32'h0);
    chk("rst_mid_data", resData, 32'h0);
    chk("rst_mid_ready", 32'(rdReady), 32'h0);
    reset = 1'b0;
    waitInit("reinit");
    doRead("rd_rezeroed", 5'd3, 2'd1, 2'd1, 3'd1, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vrf_bank_read_responder.md
# vrf_bank_read_responder

Responder end of the VRF read-request protocol: one VRF bank with one read port and one write port. It accepts `vrfReadRequest` handshakes from a lane read pipe and returns the addressed 32-bit word on `vrfReadResult` exactly two cycles after the handshake. That fixed latency is the one the requesting pipe's two-stage fire delay line depends on. After reset, the bank clears its storage to zero before it accepts any traffic.

## Interface
Parameters:
- `regNumBits`, default 5: number of vector-register index bits (32 registers).
- `offsetBits`, default 2: number of word-offset bits within one register.
- `dataWidth`, default 32: word width. Must be a multiple of 8.
- Bank depth is derived: DEPTH = 2^(regNumBits+offsetBits), which is 128 with the defaults.

Ports:
- `clock` in 1: the single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `vrfReadRequest_ready` out 1: the bank can accept a read this cycle.
- `vrfReadRequest_valid` in 1: a read request is present.
- `vrfReadRequest_bits_vs` in regNumBits: vector register index.
- `vrfReadRequest_bits_offset` in offsetBits: word offset within the register.
- `vrfReadRequest_bits_readSource` in 2: requester source tag.
- `vrfReadRequest_bits_instructionIndex` in 3: instruction tag.
- `vrfReadResult` out dataWidth: read data.
- `vrfReadResultValid` out 1: one-cycle pulse marking that `vrfReadResult` is new.
- `vrfReadResultSource` out 2: `readSource` of the returning read.
- `vrfReadResultInstructionIndex` out 3: `instructionIndex` of the returning read.
- `vrfWriteRequest_ready` out 1: the bank can accept a write this cycle.
- `vrfWriteRequest_valid` in 1: a write request is present.
- `vrfWriteRequest_bits_vs` in regNumBits: vector register index.
- `vrfWriteRequest_bits_offset` in offsetBits: word offset within the register.
- `vrfWriteRequest_bits_data` in dataWidth: write data.
- `vrfWriteRequest_bits_mask` in dataWidth/8: byte enables.

## Operation
- Address: addr = {vs, offset}, where vs is the MSBs.
- A read fires when `vrfReadRequest_ready & vrfReadRequest_valid`. A write fires when `vrfWriteRequest_ready & vrfWriteRequest_valid`.
- FSM states:
  - INIT: counter `initPtr` runs 0..DEPTH-1 and writes zero to entry `initPtr` each cycle. Both ready outputs are 0. When `initPtr` == DEPTH-1, the next state is RUN.
  - RUN: both ready outputs are 1 every cycle. There is no read/write port conflict because the bank is a true 1R1W array.
- Reset forces INIT with `initPtr` = 0 from any state.
- Write: on a write fire, byte i of the entry is replaced by data byte i where mask[i] = 1. Bytes with mask[i] = 0 are unchanged. A mask of all zeros is a legal no-op.
- Read pipeline:
  - S1 (end of fire cycle T): register the address and tags, and set the valid bit s1V.
  - S2 (end of T+1): read the array at the S1 address into the data register, copy the tags, and set resVld = s1V.
  - Forwarding: if a write fires in cycle T+1 to the same address, the returned word uses the write's masked bytes merged over the array contents. Rule: a read observes every write that fired in cycles ≤ T+1 and no later write.
- A write to the same address in cycle T as the read fire is covered by the same rule; it is visible in the returned word.
- Outputs:
  - `vrfReadResult`, `vrfReadResultSource` and `vrfReadResultInstructionIndex` are driven from the S2 registers.
  - These registers load only when s1V = 1, so the last result is held between reads.
  - `vrfReadResultValid` = resVld.
- Back-to-back reads every cycle are supported. Throughput is one read per cycle with no bubbles.

## Timing
- Read latency: a handshake in cycle T gives `vrfReadResult` valid throughout cycle T+2, with `vrfReadResultValid` = 1 in T+2 only.
- Write latency: a write firing in T is visible to a read that fires in T or later. It is also visible to an in-flight read whose S2 stage is cycle T, through forwarding.
- Reset values:
  - `vrfReadRequest_ready` = 0 and `vrfWriteRequest_ready` = 0.
  - `vrfReadResultValid` = 0.
  - `vrfReadResult` = 0, `vrfReadResultSource` = 0, `vrfReadResultInstructionIndex` = 0.
  - s1V = 0, FSM = INIT.
- Init duration: reset is deasserted in cycle 0, INIT clears entries in cycles 0..DEPTH-1, and the ready outputs rise in cycle DEPTH (128 with defaults).
- Reset mid-operation:
  - In-flight reads are dropped; no `vrfReadResultValid` pulse follows the reset.
  - Array contents are re-zeroed by INIT.
  - Requests presented during INIT are ignored and not acknowledged.
- The ready outputs do not depend combinationally on any valid input.

## Test plan
- Reset, then idle: both ready outputs are 0 for exactly 128 cycles after reset deasserts and 1 from cycle 128. A read of addr 0x7F then returns 0x00000000 with `vrfReadResultValid` high at fire+2.
- Write vs=3, offset=1, data 0xDEADBEEF, mask 0xF, then read vs=3, offset=1 → 0xDEADBEEF at fire+2, with the request's source and instructionIndex echoed.
- Partial write: entry holds 0xDEADBEEF; write data 0x11223344 with mask 0b0101 → a later read returns 0xDE22BE44.
- Forwarding: read addr 5 fires in T, and a write of 0xCAFEF00D (mask 0xF) to addr 5 fires in T+1 → result is 0xCAFEF00D. The same write fired in T+2 instead → result is the old value.
- Back-to-back: reads of addrs 0, 1, 2, 3 in consecutive cycles, with each entry prewritten to addr×0x01010101 → `vrfReadResultValid` high for 4 consecutive cycles, returning 0x0, 0x01010101, 0x02020202, 0x03030303 in order.
- Reset asserted in the cycle after a read fires → no result pulse. Ready outputs are low again for 128 cycles, and the previously written entry reads back as 0.
